// File: rtl/pic_pkg.sv
// pic_pkg: shared trigger-mode encoding and default sizing for the interrupt request front end
package pic_pkg;
    localparam logic LEVEL           = 1'b1;
    localparam logic EDGE            = 1'b0;
    localparam int   NUM_IR_DEF      = 8;
    localparam int   SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/ir_request_capture_if.sv
// ir_request_capture_if: control/status bundle between the request capture block and the PIC core
interface ir_request_capture_if
    import pic_pkg::*;
#(
    parameter int NUM_IR = NUM_IR_DEF
);
    localparam int ID_W = $clog2(NUM_IR);
    logic [NUM_IR-1:0] level_or_edge_triggered_mode;
    logic [NUM_IR-1:0] clear_ir_line;
    logic              freeze;
    logic [NUM_IR-1:0] ir_req_pin;
    logic [NUM_IR-1:0] interrupt_req_reg;
    logic [NUM_IR-1:0] overrun;
    logic              any_request;
    logic [ID_W-1:0]   highest_req_id;
    modport master (
        output level_or_edge_triggered_mode, clear_ir_line, freeze, ir_req_pin,
        input  interrupt_req_reg, overrun, any_request, highest_req_id
    );
    modport slave (
        input  level_or_edge_triggered_mode, clear_ir_line, freeze, ir_req_pin,
        output interrupt_req_reg, overrun, any_request, highest_req_id
    );
endinterface

// File: rtl/ir_sync_chain.sv
// ir_sync_chain: falling-edge flip-flop synchroniser for one asynchronous request pin
module ir_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;
    // truncating cast keeps the shift valid for a single-stage chain
    always_ff @(negedge clk or posedge reset)
        if (reset) r_sync <= '0;
        else       r_sync <= SYNC_STAGES'({r_sync, i_d});
    assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/ir_request_capture.sv
// ir_request_capture: synchronises request pins and maintains the IRR, pending edges and sticky overrun flags
module ir_request_capture
    import pic_pkg::*;
#(
    parameter int NUM_IR      = NUM_IR_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic               clk,
    input logic               reset,
    ir_request_capture_if.slave bus
);
    localparam int ID_W = $clog2(NUM_IR);
    logic [NUM_IR-1:0] w_s, w_rise, w_fire, w_lvl, w_clr, w_frz;
    logic [NUM_IR-1:0] r_p, r_pend, r_irr, r_ovr;
    genvar i;
    for (i = 0; i < NUM_IR; i++) begin : g_sync
        ir_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .i_d   (bus.ir_req_pin[i]),
            .o_q   (w_s[i])
        );
    end
    assign w_rise = w_s & ~r_p;
    assign w_fire = w_rise | r_pend;
    assign w_lvl  = bus.level_or_edge_triggered_mode ^ {NUM_IR{~LEVEL}};
    assign w_clr  = bus.clear_ir_line;
    assign w_frz  = {NUM_IR{bus.freeze}};
    // per-bit priority: clear, then freeze, then the mode-specific update
    always_ff @(negedge clk or posedge reset)
        if (reset) begin
            r_p    <= '0;
            r_pend <= '0;
            r_irr  <= '0;
            r_ovr  <= '0;
        end else begin
            r_p    <= w_s;
            r_pend <= (w_clr & w_rise) | (~w_clr & w_frz & (r_pend | (~w_lvl & w_rise)));
            r_irr  <= ~w_clr & ((w_frz & r_irr) | (~w_frz & ((~w_lvl & (r_irr | w_fire)) | (w_lvl & w_s))));
            r_ovr  <= ~w_clr & (r_ovr | (~w_frz & ~w_lvl & r_irr & w_fire));
        end
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IR-1:0] v);
        logic [ID_W-1:0] res;
        res = '0;
        for (int k = NUM_IR - 1; k >= 0; k--) if (v[k]) res = ID_W'(k);
        return res;
    endfunction
    assign bus.interrupt_req_reg = r_irr;
    assign bus.overrun           = r_ovr;
    assign bus.any_request       = |r_irr;
    assign bus.highest_req_id    = lowest_set(r_irr);
endmodule

// File: tb/tb_ir_request_capture.sv
// tb_ir_request_capture: directed checks of the request capture block at NUM_IR = 8 and 16
module tb_ir_request_capture;
    logic        clk = 1'b1;
    logic        reset;
    logic [15:0] mode, clr, pin;
    logic        frz;
    int          n_tests = 0;
    int          n_fail  = 0;

    ir_request_capture_if #(.NUM_IR(8))  b8 ();
    ir_request_capture_if #(.NUM_IR(16)) b16 ();

    assign b8.level_or_edge_triggered_mode  = mode[7:0];
    assign b8.clear_ir_line                 = clr[7:0];
    assign b8.freeze                        = frz;
    assign b8.ir_req_pin                    = pin[7:0];
    assign b16.level_or_edge_triggered_mode = mode;
    assign b16.clear_ir_line                = clr;
    assign b16.freeze                       = frz;
    assign b16.ir_req_pin                   = pin;

    ir_request_capture #(.NUM_IR(8), .SYNC_STAGES(2)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );
    ir_request_capture #(.NUM_IR(16), .SYNC_STAGES(2)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_irr(input string tag, input logic [15:0] exp);
        chk({tag, "_irr8"},  32'(b8.interrupt_req_reg),  32'(exp[7:0]));
        chk({tag, "_irr16"}, 32'(b16.interrupt_req_reg), 32'(exp));
    endtask

    task automatic chk_ovr(input string tag, input logic [15:0] exp);
        chk({tag, "_ovr8"},  32'(b8.overrun),  32'(exp[7:0]));
        chk({tag, "_ovr16"}, 32'(b16.overrun), 32'(exp));
    endtask

    task automatic chk_idle(input string tag);
        chk_irr(tag, 16'h0);
        chk_ovr(tag, 16'h0);
        chk({tag, "_any8"},  32'(b8.any_request),     32'd0);
        chk({tag, "_any16"}, 32'(b16.any_request),    32'd0);
        chk({tag, "_id8"},   32'(b8.highest_req_id),  32'd0);
        chk({tag, "_id16"},  32'(b16.highest_req_id), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        mode  = '0;
        clr   = '0;
        pin   = '0;
        frz   = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;

        // edge capture on ch3 with two-edge latency, held until cleared
        pin = 16'h0008;
        tick();
        chk_irr("e3_edge0", 16'h0);
        tick();
        chk_irr("e3_edge1", 16'h0);
        tick();
        chk_irr("e3_edge2", 16'h0008);
        chk("e3_id8", 32'(b8.highest_req_id), 32'd3);
        chk("e3_any8", 32'(b8.any_request), 32'd1);
        pin = 16'h0;
        tick();
        tick();
        chk_irr("e3_hold", 16'h0008);
        clr = 16'h0008;
        tick();
        clr = 16'h0;
        chk_irr("e3_clear", 16'h0);

        // level mode ch5 mirrors a four-cycle pulse two edges late
        mode = 16'h0020;
        pin  = 16'h0020;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 4) pin = 16'h0;
            chk_irr($sformatf("lvl5_t%0d", t), (t >= 3 && t <= 6) ? 16'h0020 : 16'h0);
            if (t == 3) begin
                chk("lvl5_id16", 32'(b16.highest_req_id), 32'd5);
                chk("lvl5_any16", 32'(b16.any_request), 32'd1);
            end
        end
        mode = 16'h0;

        // an edge during freeze is held pending and lands on the first non-freeze edge
        frz = 1'b1;
        pin = 16'h0002;
        for (int t = 1; t <= 4; t++) tick();
        chk_irr("frz_hold", 16'h0);
        frz = 1'b0;
        tick();
        chk_irr("frz_release", 16'h0002);
        pin = 16'h0;
        clr = 16'h0002;
        tick();
        clr = 16'h0;
        chk_irr("frz_clear", 16'h0);
        chk_ovr("frz_noovr", 16'h0);

        // second pulse on ch0 while its IRR bit is set raises a sticky overrun
        pin = 16'h0001;
        tick();
        pin = 16'h0;
        tick();
        tick();
        chk_irr("ovr_first", 16'h0001);
        chk_ovr("ovr_first", 16'h0);
        pin = 16'h0001;
        tick();
        pin = 16'h0;
        tick();
        tick();
        chk_irr("ovr_second", 16'h0001);
        chk_ovr("ovr_second", 16'h0001);
        clr = 16'h0001;
        tick();
        clr = 16'h0;
        chk_irr("ovr_clear", 16'h0);
        chk_ovr("ovr_clear", 16'h0);

        // clear coinciding with a rise on ch2 defers the rise by one edge
        pin = 16'h0004;
        tick();
        tick();
        clr = 16'h0004;
        tick();
        clr = 16'h0;
        chk_irr("clr_rise_same", 16'h0);
        tick();
        chk_irr("clr_rise_next", 16'h0004);
        pin = 16'h0044;
        tick();
        tick();
        tick();
        chk_irr("ch2_ch6", 16'h0044);
        chk("ch2_ch6_id8", 32'(b8.highest_req_id), 32'd2);
        chk("ch2_ch6_id16", 32'(b16.highest_req_id), 32'd2);

        // channel 12 exists only on the wide instance
        clr = 16'hFFFF;
        pin = 16'h1000;
        tick();
        clr = 16'h0;
        tick();
        tick();
        chk_irr("ch12", 16'h1000);
        chk("ch12_id16", 32'(b16.highest_req_id), 32'd12);
        chk("ch12_any8", 32'(b8.any_request), 32'd0);

        // build IRR, overrun and a pending edge, then reset mid-freeze
        clr = 16'hFFFF;
        pin = 16'h0010;
        tick();
        clr = 16'h0;
        tick();
        tick();
        chk_irr("rst_setup", 16'h0010);
        pin = 16'h0;
        tick();
        pin = 16'h0010;
        tick();
        tick();
        tick();
        chk_ovr("rst_setup", 16'h0010);
        frz = 1'b1;
        pin = 16'h0012;
        tick();
        tick();
        tick();
        chk_irr("rst_frozen", 16'h0010);
        #2 reset = 1'b1;
        #1 chk_idle("rst_async");
        tick();
        frz   = 1'b0;
        reset = 1'b0;
        tick();
        chk_irr("rst_rel0", 16'h0);
        tick();
        chk_irr("rst_rel1", 16'h0);
        tick();
        chk_irr("rst_rel2", 16'h0012);
        chk("rst_rel2_id8", 32'(b8.highest_req_id), 32'd1);
        chk_ovr("rst_rel2", 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
